// File: rtl/pc_gen_unit_if.sv
// Fetch-side handshake between pc_gen_unit and the IF stage: PC offer with epoch tag, valid/ready.
interface pc_gen_unit_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned EPOCH_W = 2
);
  logic               pc_valid_o;
  logic               pc_ready_i;
  logic [XLEN-1:0]    pc_o;
  logic [EPOCH_W-1:0] epoch_o;

  modport master (
    output pc_valid_o,
    output pc_o,
    output epoch_o,
    input  pc_ready_i
  );

  modport slave (
    input  pc_valid_o,
    input  pc_o,
    input  epoch_o,
    output pc_ready_i
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Next-PC generator: prioritised redirects, static prediction, sequential fetch, stall and halt.
// Optional misaligned-target trapping is enabled by defining PCG_ALIGN_CHECK_EN.
module pc_gen_unit #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NUM_REDIR   = 2,
  parameter int unsigned FETCH_BYTES = 4,
  parameter logic [63:0] START_PC    = 64'h8000_0000,
  parameter int unsigned EPOCH_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
  input  logic                      pred_valid_i,
  input  logic [XLEN-1:0]           pred_target_i,
  input  logic                      stall_i,
  input  logic                      halt_i,
  input  logic                      resume_i,
  input  logic [XLEN-1:0]           trap_vec_i,
  pc_gen_unit_if.master             fetch,
  output logic [NUM_REDIR-1:0]      redir_grant_o,
  output logic                      misalign_o
);

  localparam logic [XLEN-1:0] START = START_PC[XLEN-1:0];
  localparam logic [XLEN-1:0] STEP  = XLEN'(FETCH_BYTES);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  logic [NUM_REDIR-1:0] grant;
  logic [XLEN-1:0]      redir_tgt;
  logic                 redir_any;
  logic                 pc_valid;
  logic                 fire;
  logic                 pred_ok;

`ifdef PCG_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] CHK_MASK = (FETCH_BYTES == 2) ? XLEN'(1) : XLEN'(3);
  logic misalign_q, misalign_d;
  assign misalign_o = misalign_q;
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(FETCH_BYTES - 1));
  logic unused_trap_vec;
  assign unused_trap_vec = ^trap_vec_i;
  assign misalign_o      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epoch_d   = epoch_q;
    grant     = '0;
    redir_tgt = '0;
    redir_any = 1'b0;
`ifdef PCG_ALIGN_CHECK_EN
    misalign_d = 1'b0;
    pred_ok    = pred_valid_i && ((pred_target_i & CHK_MASK) == '0);
`else
    pred_ok    = pred_valid_i;
`endif

    // Lowest-index channel wins; BOOT ignores redirects entirely.
    for (int unsigned k = 0; k < NUM_REDIR; k++) begin
      if (redir_valid_i[k] && !redir_any && state_q != ST_BOOT) begin
        grant[k]  = 1'b1;
        redir_tgt = redir_pc_i[k*XLEN +: XLEN];
        redir_any = 1'b1;
      end
    end

    pc_valid = (state_q == ST_RUN) && !stall_i;
    fire     = pc_valid && fetch.pc_ready_i;

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!redir_any && halt_i) state_d = ST_HALT;
      ST_HALT: if (redir_any || resume_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (redir_any) begin
      epoch_d = epoch_q + EPOCH_W'(1);
`ifdef PCG_ALIGN_CHECK_EN
      if ((redir_tgt & CHK_MASK) != '0) begin
        pc_d       = trap_vec_i;
        misalign_d = 1'b1;
      end else begin
        pc_d = redir_tgt;
      end
`else
      pc_d = redir_tgt & ALIGN_MASK;
`endif
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (fire && pred_ok) begin
`ifdef PCG_ALIGN_CHECK_EN
      pc_d = pred_target_i;
`else
      pc_d = pred_target_i & ALIGN_MASK;
`endif
    end else if (fire) begin
      pc_d = pc_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= START;
      epoch_q <= '0;
`ifdef PCG_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
`ifdef PCG_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign fetch.pc_valid_o = pc_valid && !rst;
  assign fetch.pc_o       = pc_q;
  assign fetch.epoch_o    = epoch_q;
  assign redir_grant_o    = rst ? '0 : grant;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: reset/boot, sequential fetch, backpressure, redirects, epoch wrap,
// prediction, halt/resume, misaligned redirect and mid-run reset.
module tb_pc_gen_unit;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NR   = 2;
  localparam int unsigned EW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   redir_valid_i;
  logic [XLEN-1:0] redir_pc0, redir_pc1;
  logic            pred_valid_i;
  logic [XLEN-1:0] pred_target_i;
  logic            stall_i, halt_i, resume_i;
  logic [XLEN-1:0] trap_vec_i;
  logic [NR-1:0]   redir_grant_o;
  logic            misalign_o;

  int checks = 0;
  int errors = 0;

  pc_gen_unit_if #(.XLEN(XLEN), .EPOCH_W(EW)) fif ();

  pc_gen_unit #(
    .XLEN(XLEN), .NUM_REDIR(NR), .FETCH_BYTES(4),
    .START_PC(64'h8000_0000), .EPOCH_W(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .redir_valid_i(redir_valid_i), .redir_pc_i({redir_pc1, redir_pc0}),
    .pred_valid_i(pred_valid_i), .pred_target_i(pred_target_i),
    .stall_i(stall_i), .halt_i(halt_i), .resume_i(resume_i),
    .trap_vec_i(trap_vec_i), .fetch(fif),
    .redir_grant_o(redir_grant_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redir_valid_i  = '0;
    redir_pc0      = '0;
    redir_pc1      = '0;
    pred_valid_i   = 1'b0;
    pred_target_i  = '0;
    stall_i        = 1'b0;
    halt_i         = 1'b0;
    resume_i       = 1'b0;
    trap_vec_i     = '0;
    fif.pc_ready_i = 1'b1;
  endtask

  // Leaves the DUT in RUN at START_PC, epoch 0.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({fif.pc_valid_o, fif.pc_o, fif.epoch_o, redir_grant_o, misalign_o} !==
        {1'b0, 64'h8000_0000, 2'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: valid=%b pc=%h epoch=%0d grant=%b mis=%b, want 0 80000000 0 00 0",
               fif.pc_valid_o, fif.pc_o, fif.epoch_o, redir_grant_o, misalign_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fif.pc_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL boot_valid: got %b want 0", fif.pc_valid_o);
    end
  endtask

  task automatic test_sequential();
    logic [XLEN-1:0] exp_pc;
    tick();
    exp_pc = 64'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({fif.pc_valid_o, fif.pc_o} !== {1'b1, exp_pc}) begin
        errors++;
        $display("FAIL seq_pc[%0d]: valid=%b pc=%h want 1 %h", i, fif.pc_valid_o, fif.pc_o, exp_pc);
      end
      exp_pc = exp_pc + 64'd4;
      tick();
    end
  endtask

  task automatic test_boot_ignores_redirect();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    redir_valid_i = 2'b01;
    redir_pc0     = 64'h5000;
    #1;
    checks++;
    if (redir_grant_o !== 2'b00) begin
      errors++;
      $display("FAIL boot_grant: got %b want 00", redir_grant_o);
    end
    tick();
    redir_valid_i = '0;
    checks++;
    if ({fif.pc_o, fif.epoch_o} !== {64'h8000_0000, 2'd0}) begin
      errors++;
      $display("FAIL boot_ignore: pc=%h epoch=%0d want 80000000 0", fif.pc_o, fif.epoch_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick();
    fif.pc_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({fif.pc_valid_o, fif.pc_o, fif.epoch_o} !== {1'b1, 64'h8000_0004, 2'd0}) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b pc=%h epoch=%0d want 1 80000004 0",
                 i, fif.pc_valid_o, fif.pc_o, fif.epoch_o);
      end
      tick();
    end
    fif.pc_ready_i = 1'b1;
    tick();
    checks++;
    if (fif.pc_o !== 64'h8000_0008) begin
      errors++;
      $display("FAIL backpressure_release: pc=%h want 80000008", fif.pc_o);
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    redir_valid_i = 2'b11;
    redir_pc0     = 64'h1000;
    redir_pc1     = 64'h2000;
    #1;
    checks++;
    if (redir_grant_o !== 2'b01) begin
      errors++;
      $display("FAIL grant_both: got %b want 01", redir_grant_o);
    end
    tick();
    redir_valid_i = '0;
    checks++;
    if ({fif.pc_o, fif.epoch_o} !== {64'h1000, 2'd1}) begin
      errors++;
      $display("FAIL redir_ch0: pc=%h epoch=%0d want 1000 1", fif.pc_o, fif.epoch_o);
    end
    redir_valid_i = 2'b10;
    #1;
    checks++;
    if (redir_grant_o !== 2'b10) begin
      errors++;
      $display("FAIL grant_ch1: got %b want 10", redir_grant_o);
    end
    tick();
    redir_valid_i = '0;
    checks++;
    if ({fif.pc_o, fif.epoch_o} !== {64'h2000, 2'd2}) begin
      errors++;
      $display("FAIL redir_ch1: pc=%h epoch=%0d want 2000 2", fif.pc_o, fif.epoch_o);
    end
  endtask

  // Continues from test_redirect_priority: pc 0x2000, epoch 2.
  task automatic test_stall_and_wrap();
    stall_i       = 1'b1;
    redir_valid_i = 2'b10;
    redir_pc1     = 64'h3000;
    #1;
    checks++;
    if ({fif.pc_valid_o, redir_grant_o} !== {1'b0, 2'b10}) begin
      errors++;
      $display("FAIL stall_redir: valid=%b grant=%b want 0 10", fif.pc_valid_o, redir_grant_o);
    end
    tick();
    redir_valid_i = '0;
    checks++;
    if ({fif.pc_o, fif.epoch_o} !== {64'h3000, 2'd3}) begin
      errors++;
      $display("FAIL stall_redir_pc: pc=%h epoch=%0d want 3000 3", fif.pc_o, fif.epoch_o);
    end
    tick();
    checks++;
    if ({fif.pc_valid_o, fif.pc_o} !== {1'b0, 64'h3000}) begin
      errors++;
      $display("FAIL stall_hold: valid=%b pc=%h want 0 3000", fif.pc_valid_o, fif.pc_o);
    end
    stall_i       = 1'b0;
    redir_valid_i = 2'b01;
    redir_pc0     = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redir_valid_i = '0;
    checks++;
    if ({fif.pc_o, fif.epoch_o} !== {64'hFFFF_FFFF_FFFF_FFFC, 2'd0}) begin
      errors++;
      $display("FAIL epoch_wrap: pc=%h epoch=%0d want fffffffffffffffc 0", fif.pc_o, fif.epoch_o);
    end
    tick();
    checks++;
    if (fif.pc_o !== 64'h0) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h want 0", fif.pc_o);
    end
  endtask

  task automatic test_prediction();
    do_reset();
    pred_valid_i  = 1'b1;
    pred_target_i = 64'h4000;
    tick();
    checks++;
    if (fif.pc_o !== 64'h4000) begin
      errors++;
      $display("FAIL pred_taken: pc=%h want 4000", fif.pc_o);
    end
    fif.pc_ready_i = 1'b0;
    pred_target_i  = 64'h9000;
    tick();
    checks++;
    if (fif.pc_o !== 64'h4000) begin
      errors++;
      $display("FAIL pred_no_fire: pc=%h want 4000", fif.pc_o);
    end
    fif.pc_ready_i = 1'b1;
    stall_i        = 1'b1;
    tick();
    stall_i = 1'b0;
    checks++;
    if (fif.pc_o !== 64'h4000) begin
      errors++;
      $display("FAIL pred_stall: pc=%h want 4000", fif.pc_o);
    end
    pred_target_i = 64'h5002;
    tick();
    pred_valid_i = 1'b0;
    checks++;
`ifdef PCG_ALIGN_CHECK_EN
    if (fif.pc_o !== 64'h4004) begin
      errors++;
      $display("FAIL pred_misaligned: pc=%h want 4004", fif.pc_o);
    end
`else
    if (fif.pc_o !== 64'h5000) begin
      errors++;
      $display("FAIL pred_masked: pc=%h want 5000", fif.pc_o);
    end
`endif
  endtask

  task automatic test_halt();
    do_reset();
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({fif.pc_valid_o, fif.pc_o} !== {1'b0, 64'h8000_0004}) begin
        errors++;
        $display("FAIL halt_hold[%0d]: valid=%b pc=%h want 0 80000004", i, fif.pc_valid_o, fif.pc_o);
      end
      tick();
    end
    resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    checks++;
    if ({fif.pc_valid_o, fif.pc_o} !== {1'b1, 64'h8000_0004}) begin
      errors++;
      $display("FAIL resume: valid=%b pc=%h want 1 80000004", fif.pc_valid_o, fif.pc_o);
    end
    halt_i        = 1'b1;
    redir_valid_i = 2'b01;
    redir_pc0     = 64'h6000;
    tick();
    redir_valid_i = '0;
    halt_i        = 1'b0;
    checks++;
    if ({fif.pc_valid_o, fif.pc_o, fif.epoch_o} !== {1'b1, 64'h6000, 2'd1}) begin
      errors++;
      $display("FAIL halt_vs_redir: valid=%b pc=%h epoch=%0d want 1 6000 1",
               fif.pc_valid_o, fif.pc_o, fif.epoch_o);
    end
    halt_i = 1'b1;
    tick();
    halt_i        = 1'b0;
    redir_valid_i = 2'b10;
    redir_pc1     = 64'h7000;
    #1;
    checks++;
    if ({fif.pc_valid_o, redir_grant_o} !== {1'b0, 2'b10}) begin
      errors++;
      $display("FAIL halt_grant: valid=%b grant=%b want 0 10", fif.pc_valid_o, redir_grant_o);
    end
    tick();
    redir_valid_i = '0;
    checks++;
    if ({fif.pc_valid_o, fif.pc_o, fif.epoch_o} !== {1'b1, 64'h7000, 2'd2}) begin
      errors++;
      $display("FAIL halt_redir_wake: valid=%b pc=%h epoch=%0d want 1 7000 2",
               fif.pc_valid_o, fif.pc_o, fif.epoch_o);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    fif.pc_ready_i = 1'b0;
    redir_valid_i  = 2'b01;
    redir_pc0      = 64'h1002;
    trap_vec_i     = 64'h8000;
    tick();
    redir_valid_i = '0;
    checks++;
`ifdef PCG_ALIGN_CHECK_EN
    if ({fif.pc_o, fif.epoch_o, misalign_o} !== {64'h8000, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL misalign_trap: pc=%h epoch=%0d mis=%b want 8000 1 1",
               fif.pc_o, fif.epoch_o, misalign_o);
    end
`else
    if ({fif.pc_o, fif.epoch_o, misalign_o} !== {64'h1000, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL misalign_masked: pc=%h epoch=%0d mis=%b want 1000 1 0",
               fif.pc_o, fif.epoch_o, misalign_o);
    end
`endif
    tick();
    checks++;
    if (misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: mis=%b want 0", misalign_o);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    tick();
    tick();
    rst           = 1'b1;
    redir_valid_i = 2'b01;
    redir_pc0     = 64'hA000;
    #1;
    checks++;
    if ({fif.pc_valid_o, redir_grant_o} !== {1'b0, 2'b00}) begin
      errors++;
      $display("FAIL rst_outputs: valid=%b grant=%b want 0 00", fif.pc_valid_o, redir_grant_o);
    end
    tick();
    rst           = 1'b0;
    redir_valid_i = '0;
    #1;
    checks++;
    if ({fif.pc_valid_o, fif.pc_o, fif.epoch_o} !== {1'b0, 64'h8000_0000, 2'd0}) begin
      errors++;
      $display("FAIL rst_mid_run: valid=%b pc=%h epoch=%0d want 0 80000000 0",
               fif.pc_valid_o, fif.pc_o, fif.epoch_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_boot_ignores_redirect();
    test_backpressure();
    test_redirect_priority();
    test_stall_and_wrap();
    test_prediction();
    test_halt();
    test_misalign();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
